// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Bit-counter width for a given operand width; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// Combinational full subtractor built from two chained half subtractors.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic d1;
    logic b1;
    logic b2;

    half_subtractor u_hs0 (
        .a   (a),
        .b   (b),
        .d   (d1),
        .bor (b1)
    );

    half_subtractor u_hs1 (
        .a   (d1),
        .b   (bin),
        .d   (d),
        .bor (b2)
    );

    assign bout = b1 | b2;

endmodule

// File: rtl/half_subtractor.sv
// Combinational half subtractor: d = a - b, bor = borrow out.
module half_subtractor (
    input  logic a,
    input  logic b,
    output logic d,
    output logic bor
);

    assign d   = a ^ b;
    assign bor = ~a & b;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first, with start/busy/done handshake.
// Define SERIAL_SUB_SAT_EN to clamp the result to zero when a < b.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bor
);

    localparam int unsigned CW = cnt_width(WIDTH);

    state_e           state_q;
    logic [WIDTH-1:0] sa_q;
    logic [WIDTH-1:0] sb_q;
    logic [WIDTH-1:0] res_q;
    logic             borrow_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] diff_q;
    logic             bor_q;

    logic             d_c;
    logic             bo_c;
    logic [WIDTH-1:0] res_d;
    logic [WIDTH-1:0] final_d;
    logic             last_c;

    full_subtractor u_fs (
        .a    (sa_q[0]),
        .b    (sb_q[0]),
        .bin  (borrow_q),
        .d    (d_c),
        .bout (bo_c)
    );

    assign res_d  = {d_c, res_q[WIDTH-1:1]};
    assign last_c = (cnt_q == CW'(WIDTH - 1));

`ifdef SERIAL_SUB_SAT_EN
    assign final_d = bo_c ? '0 : res_d;
`else
    assign final_d = res_d;
`endif

    // FSM, datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            sa_q     <= '0;
            sb_q     <= '0;
            res_q    <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            diff_q   <= '0;
            bor_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        sa_q     <= a;
                        sb_q     <= b;
                        borrow_q <= 1'b0;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= SHIFT;
                    end else begin
                        state_q  <= IDLE;
                    end
                end
                SHIFT: begin
                    res_q    <= res_d;
                    sa_q     <= {1'b0, sa_q[WIDTH-1:1]};
                    sb_q     <= {1'b0, sb_q[WIDTH-1:1]};
                    borrow_q <= bo_c;
                    cnt_q    <= cnt_q + CW'(1);
                    if (last_c) begin
                        diff_q  <= final_d;
                        bor_q   <= bo_c;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign bor  = bor_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8) against an arithmetic model.
module tb_serial_subtractor;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a_s;
    logic [W-1:0] b_s;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bor;

    int checks = 0;
    int errors = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a_s),
        .b     (b_s),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bor   (bor)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] model_diff(input logic [W-1:0] x, input logic [W-1:0] y);
        int unsigned r;
`ifdef SERIAL_SUB_SAT_EN
        if (x < y) return '0;
`endif
        r = (int'(x) - int'(y) + (1 << W)) % (1 << W);
        return W'(r);
    endfunction

    function automatic logic model_bor(input logic [W-1:0] x, input logic [W-1:0] y);
        return x < y;
    endfunction

    // Issue one op from IDLE; optionally disturb inputs/start while shifting.
    task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input bit disturb,
                         input string tag);
        @(negedge clk);
        a_s = x; b_s = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < int'(W); i++) begin
            check({tag, " busy"}, 32'(busy), 32'd1);
            check({tag, " early_done"}, 32'(done), 32'd0);
            if (disturb) begin
                a_s   = W'($urandom);
                b_s   = W'($urandom);
                start = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
        end
        start = 1'b0;
        check({tag, " done"}, 32'(done), 32'd1);
        check({tag, " busy_at_done"}, 32'(busy), 32'd0);
        check({tag, " diff"}, 32'(diff), 32'(model_diff(x, y)));
        check({tag, " bor"}, 32'(bor), 32'(model_bor(x, y)));
        @(negedge clk);
        check({tag, " done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] hd;
        logic         hb;
        logic [W-1:0] x;
        logic [W-1:0] y;
        int           seen;

        rst = 1'b1; start = 1'b0; a_s = '0; b_s = '0;
        #1;
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst diff", 32'(diff), 32'd0);
        check("rst bor", 32'(bor), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        do_op(8'd200, 8'd55, 1'b0, "200-55");
        do_op(8'd5, 8'd10, 1'b0, "5-10");
        do_op(8'h00, 8'h01, 1'b0, "0-1");
        do_op(8'hAA, 8'hAA, 1'b0, "AA-AA");
        do_op(8'd9, 8'd4, 1'b1, "9-4 ign");
        do_op(8'hFF, 8'h00, 1'b0, "FF-0");
        do_op(8'h00, 8'hFF, 1'b0, "0-FF");

        // start held through DONE: second op accepted on the DONE edge.
        @(negedge clk);
        a_s = 8'd200; b_s = 8'd100; start = 1'b1;
        @(negedge clk);
        for (int i = 0; i < int'(W) - 1; i++) @(negedge clk);
        check("b2b busy_last", 32'(busy), 32'd1);
        @(negedge clk);
        check("b2b done1", 32'(done), 32'd1);
        check("b2b diff1", 32'(diff), 32'd100);
        a_s = 8'd3; b_s = 8'd1;
        @(negedge clk);
        start = 1'b0;
        check("b2b busy2", 32'(busy), 32'd1);
        check("b2b done_low", 32'(done), 32'd0);
        for (int i = 0; i < int'(W) - 1; i++) @(negedge clk);
        check("b2b busy2_last", 32'(busy), 32'd1);
        @(negedge clk);
        check("b2b done2", 32'(done), 32'd1);
        check("b2b diff2", 32'(diff), 32'd2);
        check("b2b bor2", 32'(bor), 32'd0);
        @(negedge clk);

        // Result hold with wandering inputs.
        hd = diff; hb = bor;
        for (int i = 0; i < 20; i++) begin
            a_s = W'($urandom); b_s = W'($urandom);
            @(negedge clk);
            check("hold diff", 32'(diff), 32'd2);
            check("hold bor", 32'(bor), 32'(hb));
            check("hold busy", 32'(busy), 32'd0);
        end
        check("hold diff_ref", 32'(diff), 32'(hd));

        // Asynchronous reset mid-shift aborts the op.
        @(negedge clk);
        a_s = 8'd200; b_s = 8'd55; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst busy", 32'(busy), 32'd0);
        check("arst done", 32'(done), 32'd0);
        check("arst diff", 32'(diff), 32'd0);
        check("arst bor", 32'(bor), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        check("arst no_done", 32'(seen), 32'd0);

        // Reset released with start already high.
        rst = 1'b1;
        @(negedge clk);
        a_s = 8'd50; b_s = 8'd7; start = 1'b1; rst = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check("rel busy", 32'(busy), 32'd1);
        repeat (W) @(negedge clk);
        check("rel done", 32'(done), 32'd1);
        check("rel diff", 32'(diff), 32'd43);

        // Randomised ops against the model.
        for (int n = 0; n < 40; n++) begin
            x = W'($urandom);
            y = W'($urandom);
            if (n % 5 == 0) y = x;
            do_op(x, y, 1'($urandom_range(0, 1)), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial unsigned subtractor. It computes `diff = a - b` over `WIDTH` clock cycles, one bit per cycle, LSB first. It uses a single full-subtractor cell and a registered borrow. The block sits directly downstream of the combinational `half_subtractor` cell: it consumes that cell's `d`/`bor` outputs, chained into a full subtractor, and turns them into a multi-bit sequential datapath with a start/busy/done handshake.

## Interface
- `WIDTH`, default 8: operand and result width in bits (must be ≥ 2).
- `clk` input, 1 bit: single clock; all state updates on its rising edge.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `start` input, 1 bit: request a subtraction; sampled only in IDLE and DONE.
- `a` input, WIDTH bits: minuend, captured on the accepted `start` edge.
- `b` input, WIDTH bits: subtrahend, captured on the accepted `start` edge.
- `busy` output, 1 bit: high while bits are being shifted (SHIFT state).
- `done` output, 1 bit: one-cycle pulse; `diff`/`bor` are valid from this cycle on.
- `diff` output, WIDTH bits: result, held until the next accepted `start`.
- `bor` output, 1 bit: final borrow out; 1 exactly when `a < b` (unsigned).

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE → SHIFT when `start`=1. On that edge:
  - load `a`/`b` into shift registers;
  - clear the borrow flop;
  - clear the bit counter to 0.
- SHIFT, each edge:
  - compute `d`/`bo` of the full subtractor on `sa[0]`, `sb[0]`, `borrow_q`;
  - shift `d` into the result MSB (result register shifts right);
  - shift both operand registers right;
  - set `borrow_q <= bo`;
  - increment the counter.
- SHIFT → DONE on the edge that performs shift number WIDTH (counter == WIDTH-1).
- DONE lasts exactly one cycle with `done`=1.
  - `start`=1 in DONE: accepted immediately (loads new operands, → SHIFT).
  - Otherwise → IDLE.
- `start` during SHIFT is ignored. Operands are not re-sampled and the in-flight result is unaffected.
- `a`/`b` may change freely after the accepting edge.
- Arithmetic is modulo 2^WIDTH. `bor` is the final `borrow_q`, latched into the output register on the last shift.
- `diff`/`bor` update only on the last shift edge. They are stable in IDLE and DONE.

## Timing
- Reset values: state=IDLE, `busy`=0, `done`=0, `diff`=0, `bor`=0, borrow flop=0, counter=0.
- `start` sampled at edge N:
  - `busy`=1 for cycles after edges N … N+WIDTH-1;
  - `done`=1 for the single cycle after edge N+WIDTH;
  - latency is WIDTH clocks from the accepting edge to `done`.
- Back-to-back operation (start held or re-pulsed in DONE) gives a throughput of one result per WIDTH+1 cycles.
- Reset asserted mid-SHIFT: immediate abort, all outputs return to reset values, and no `done` is produced.
- Reset released with `start`=1: the first edge after release may accept it.

## Configuration
- `SERIAL_SUB_SAT_EN` defined: saturating mode. If the final borrow is 1, `diff` is forced to 0 on the last shift edge. `bor` still reports 1.
- Undefined: wrap-around (two's-complement) result, e.g. 5-10 → 8'hFB.

## Structure
- Shared package `serial_sub_pkg`:
  - state typedef (IDLE/SHIFT/DONE);
  - counter-width constant derived as `$clog2(WIDTH)`.
- One sub-module `full_subtractor`, purely combinational:
  - inputs `a`, `b`, `bin`; outputs `d`, `bout`;
  - built from two `half_subtractor` instances plus an OR of their borrows.
- Top level holds the FSM, the shift registers, the counter and the borrow flop.

## Test plan
All scenarios use WIDTH=8.
- Reset: assert `rst` mid-SHIFT after a=8'd200, b=8'd55 → `busy`=0, `done`=0, `diff`=0, `bor`=0 immediately (asynchronous); no `done` pulse afterwards.
- a=8'd200, b=8'd55, `start` at edge N → `busy` for 8 cycles; `done`=1 only in the cycle after edge N+8; `diff`=8'd145, `bor`=0.
- a=8'd5, b=8'd10 → `bor`=1. Without macro `diff`=8'hFB; with `SERIAL_SUB_SAT_EN` `diff`=8'h00.
- a=8'h00, b=8'h01 → full borrow ripple: `diff`=8'hFF, `bor`=1. Then a=b=8'hAA → `diff`=8'h00, `bor`=0.
- Handshake:
  - Start a=9, b=4, then pulse `start` with a=1, b=2 during SHIFT → ignored; result `diff`=8'd5, `bor`=0.
  - `start` held high through DONE with a=8'd3, b=8'd1 → new op accepted on the DONE edge; next `done` 8 cycles later with `diff`=8'd2.
- Result hold: after `done`, change `a`/`b` for 20 cycles with `start`=0 → `diff`/`bor` unchanged, `busy`=0.
